// File: rtl/maclauren_pkg.sv
// Shared types and constants for the Maclaurin series engine and its result buffer.
package maclauren_pkg;

  localparam int OUTPUT_WIDTH_DEF = 32;
  localparam int CNT_W            = 8;

  // One buffered engine result: overflow tag above the signed series value.
  typedef struct packed {
    logic                               ov;
    logic signed [OUTPUT_WIDTH_DEF-1:0] y;
  } result_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
  import maclauren_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/maclauren_result_buffer.sv
// First-word-fall-through FIFO for series-engine results, with sticky error and
// optional saturating drop/overflow statistics (enabled by MACLAUREN_RB_STATS_EN).
module maclauren_result_buffer
  import maclauren_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic signed [OUTPUT_WIDTH-1:0] in_y,
  input  logic                           in_overflow,
  input  logic                           in_error,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [OUTPUT_WIDTH:0]          out_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full,
  output logic                           empty,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic [CNT_W-1:0]               ov_cnt,
  output logic                           err_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OUTPUT_WIDTH:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          err_flag_d, err_flag_q;
  logic          push, pop, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // A flush cycle suppresses both handshakes; a pop frees the slot a same-cycle push needs.
  assign pop  = !is_empty && out_ready && !start;
  assign push = in_valid && (!is_full || pop) && !start;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_flag_d = err_flag_q | in_error;
    if (start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      err_flag_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_flag_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_flag_q <= err_flag_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_overflow, in_y};
    end
  end

  assign out_data  = mem[rd_ptr_q];
  assign out_valid = !is_empty;
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign err_flag  = err_flag_q;

`ifdef MACLAUREN_RB_STATS_EN
  logic drop_inc, ov_inc;

  // Only results that actually land in storage count as overflowed.
  assign drop_inc = in_valid && is_full && !pop && !start;
  assign ov_inc   = push && in_overflow;

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ov_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (ov_inc),
    .cnt (ov_cnt)
  );
`else
  assign drop_cnt = '0;
  assign ov_cnt   = '0;
`endif

endmodule

// File: tb/tb_maclauren_result_buffer.sv
// Scoreboard bench for maclauren_result_buffer: driver queues expected entries,
// a negedge monitor compares every accepted head entry against the queue.
module tb_maclauren_result_buffer;
  import maclauren_pkg::*;

  localparam int W = 32;
  localparam int D = 8;
`ifdef MACLAUREN_RB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, start, in_valid, in_overflow, in_error, out_ready;
  logic signed [W-1:0] in_y;
  logic                out_valid, full, empty, err_flag;
  logic [W:0]          out_data;
  logic [3:0]          count;
  logic [7:0]          drop_cnt, ov_cnt;

  result_t exp_q[$];
  int      checks   = 0;
  int      failures = 0;

  maclauren_result_buffer #(.OUTPUT_WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_y        (in_y),
    .in_overflow (in_overflow),
    .in_error    (in_error),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .drop_cnt    (drop_cnt),
    .ov_cnt      (ov_cnt),
    .err_flag    (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an accepted pop is sampled mid-cycle, before the edge that retires it.
  always @(negedge clk) begin
    if (!rst && !start && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected no entry", out_data);
      end else begin
        check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic v, input int y, input logic ov, input logic rdy, input logic keep);
    in_valid    = v;
    in_y        = y;
    in_overflow = ov;
    out_ready   = rdy;
    if (keep) exp_q.push_back('{ov: ov, y: y});
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    result_t head;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_y = '0;
    in_overflow = 1'b0; in_error = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    check("rst_ov", 64'(ov_cnt), 64'(0));
    check("rst_err", 64'(err_flag), 64'(0));
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Three pushes held back, then drained in order.
    drive(1, 5, 0, 0, 1);
    check("write_to_read_latency", 64'(out_valid), 64'(1));
    drive(1, -7, 0, 0, 1);
    drive(1, 100, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("t1_count", 64'(count), 64'(3));
    head = '{ov: 1'b0, y: 5};
    check("t1_head", 64'(out_data), 64'(head));
    repeat (3) drive(0, 0, 0, 1, 0);
    check("t1_empty", 64'(empty), 64'(1));

    // Ten pushes into eight slots: last two dropped.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1000 + i, 0, 0, i < 8);
      if (i == 7) check("t2_full_after_8", 64'(full), 64'(1));
    end
    check("t2_count", 64'(count), 64'(8));
    check("t2_drop", 64'(drop_cnt), STATS ? 64'(2) : 64'(0));

    // Push and pop together while full.
    drive(1, 999, 0, 1, 1);
    check("t3_count_held", 64'(count), 64'(8));
    check("t3_full_held", 64'(full), 64'(1));
    check("t3_drop_held", 64'(drop_cnt), STATS ? 64'(2) : 64'(0));
    repeat (8) drive(0, 0, 0, 1, 0);
    check("t3_empty", 64'(empty), 64'(1));

    // Overflow tagging, sticky error, and flush.
    flush();
    check("t4_drop_cleared", 64'(drop_cnt), 64'(0));
    drive(1, 11, 1, 0, 1);
    drive(1, 12, 0, 0, 1);
    in_error = 1'b1;
    drive(1, 13, 1, 0, 1);
    in_error = 1'b0;
    drive(1, 14, 1, 0, 1);
    drive(1, 15, 0, 0, 1);
    check("t4_err_set", 64'(err_flag), 64'(1));
    repeat (3) drive(0, 0, 0, 0, 0);
    check("t4_err_sticky", 64'(err_flag), 64'(1));
    check("t4_ov_cnt", 64'(ov_cnt), STATS ? 64'(3) : 64'(0));
    check("t4_count", 64'(count), 64'(5));
    flush();
    check("t4_flush_count", 64'(count), 64'(0));
    check("t4_flush_empty", 64'(empty), 64'(1));
    check("t4_flush_ov", 64'(ov_cnt), 64'(0));
    check("t4_flush_err", 64'(err_flag), 64'(0));

    // Saturation of the drop counter.
    for (int i = 0; i < 8; i++) drive(1, 200 + i, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      drive(1, -i, 1, 0, 0);
      if (i == 253) check("t5_drop_254", 64'(drop_cnt), STATS ? 64'(254) : 64'(0));
    end
    check("t5_drop_sat", 64'(drop_cnt), STATS ? 64'(255) : 64'(0));
    check("t5_ov_no_drops", 64'(ov_cnt), 64'(0));
    check("t5_count", 64'(count), 64'(8));

    // Asynchronous reset mid-cycle with a full queue.
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_async_empty", 64'(empty), 64'(1));
    check("t6_async_count", 64'(count), 64'(0));
    check("t6_async_valid", 64'(out_valid), 64'(0));
    check("t6_async_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 42, 1, 0, 1);
    drive(0, 0, 0, 1, 0);
    check("t6_post_empty", 64'(empty), 64'(1));
    check("t6_post_ov", 64'(ov_cnt), STATS ? 64'(1) : 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
